morse_blink_tx: RTL and testbench
=================================

Name: morse_blink_tx

Overview:
- Transmit-side counterpart to our press-duration detectors: turns a stream of Morse symbols (dot, dash, letter gap, word gap) into timed on/off durations on one LED output.
- Upstream logic (button decoder, UART bridge, ROM sequencer) pushes symbols over a valid/ready handshake.
- The block owns all timing: 1 unit = UNIT_CYCLES clocks.
- Targets the 12 MHz board clock.

Parameters:
- CLK_FREQ, 12_000_000, board clock frequency in Hz; documentation and default derivation only.
- UNIT_CYCLES, CLK_FREQ/5 (2_400_000 = 200 ms), clocks per Morse time unit; must be >= 2.
- COUNT_BITS, 24, width of the unit cycle counter; must satisfy 2^COUNT_BITS > UNIT_CYCLES.

Ports:
- CLK  input  1  board clock; all logic on rising edge.
- RST_N  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to CLK.
- SYM  input  2  symbol code: 00 dot, 01 dash, 10 letter gap, 11 word gap.
- SYM_VALID  input  1  SYM holds a valid symbol this cycle.
- SYM_READY  output  1  registered; block accepts a symbol this cycle.
- LED  output  1  registered; 1 = lamp on (mark).
- BUSY  output  1  registered; 1 while a symbol is being played (state != IDLE).

Behaviour:
- Reset values (RST_N low, asynchronous): state IDLE, LED 0, BUSY 0, SYM_READY 0, all counters 0.
  - SYM_READY rises on the first rising edge after RST_N goes high.
- States:
  - IDLE: SYM_READY 1, LED 0, BUSY 0.
  - MARK: LED 1.
  - SPACE: LED 0.
  - In MARK and SPACE: SYM_READY 0, BUSY 1.
- Handshake:
  - Transfer occurs on a rising edge where SYM_VALID=1 and SYM_READY=1.
  - SYM is sampled on that edge only.
  - SYM_READY drops to 0 on the same edge.
  - SYM_VALID while SYM_READY=0 is ignored. No buffering; upstream must hold SYM_VALID/SYM until the transfer.
- Durations: u = UNIT_CYCLES clocks.
  - Dot: MARK 1u, then SPACE 1u (intra-character gap).
  - Dash: MARK 3u, then SPACE 1u.
  - Letter gap: SPACE 3u, no MARK.
  - Word gap: SPACE 7u, no MARK.
- Timing, with transfer on edge k:
  - Dot/dash: LED=1 from edge k+1, exactly N*u cycles (N = 1 or 3), then LED=0 for exactly u cycles.
  - Gap symbols: LED stays 0 for exactly N*u cycles (N = 3 or 7).
  - Return to IDLE (SYM_READY=1, BUSY=0) on edge k+1+total, where total = 2u (dot), 4u (dash), 3u (letter gap), 7u (word gap).
  - Back-to-back symbols with SYM_VALID held high: consecutive transfers are total+1 cycles apart (one IDLE cycle between symbols).
- Counting:
  - cycle_cnt (COUNT_BITS) counts 0..UNIT_CYCLES-1 and wraps.
  - unit_cnt (3 bits) counts elapsed units; phase ends when unit_cnt reaches N-1 and cycle_cnt reaches UNIT_CYCLES-1.
  - No multiplier.
  - Both counters clear on every phase change and on entry to IDLE.
- MARK->SPACE: at end of the mark phase; the space phase is always exactly 1u.
- SPACE->IDLE: at end of the space phase.
- Reset mid-symbol: LED forced 0 immediately (asynchronous). The symbol in progress is dropped, not resumed.
- LED is a clean registered output; no glitches at phase boundaries.

Test Plan:
- Reset, UNIT_CYCLES=4: RST_N low → LED 0, BUSY 0, SYM_READY 0. Release → SYM_READY 1 on next edge.
- Dot, UNIT_CYCLES=4, transfer at edge k: LED 1 for edges k+1..k+4, LED 0 for k+5..k+8, SYM_READY 1 at k+9.
- Dash then letter gap, SYM_VALID held, UNIT_CYCLES=4:
  - Dash: LED high exactly 12 cycles, low 4 cycles.
  - Letter gap: second transfer exactly 17 cycles after the first; LED low 12 cycles.
- Word gap, UNIT_CYCLES=4: LED 0 and BUSY 1 for exactly 28 cycles. SYM_VALID toggling during BUSY causes no extra transfer.
- Reset mid-dash: assert RST_N at cycle 5 of MARK → LED 0 within the same cycle (no clock edge needed). After release: IDLE, SYM_READY 1, next dot plays full length.
- Sequence "SOS" (dot×3, letter gap, dash×3, letter gap, dot×3), UNIT_CYCLES=2:
  - Scoreboard compares the LED on/off run lengths against the expected list; exact cycle match required.

Source files
------------

// File: rtl/morse_blink_tx.sv
// Morse symbol player: dot/dash/gap symbols in, timed LED mark/space out.
// One symbol at a time over valid/ready; all timing in units of UNIT_CYCLES.
module morse_blink_tx #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int UNIT_CYCLES = CLK_FREQ / 5,
    parameter int COUNT_BITS  = 24
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] SYM,
    input  logic       SYM_VALID,
    output logic       SYM_READY,
    output logic       LED,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_SPACE
    } state_t;

    localparam logic [COUNT_BITS-1:0] CYC_LAST = COUNT_BITS'(UNIT_CYCLES - 1);

    state_t                state;
    state_t                state_nx;
    logic [COUNT_BITS-1:0] cycle_cnt;
    logic [COUNT_BITS-1:0] cycle_nx;
    logic [2:0]            unit_cnt;
    logic [2:0]            unit_nx;
    logic [2:0]            last_unit;
    logic [2:0]            last_nx;
    logic                  take;
    logic                  unit_end;
    logic                  phase_end;

    assign take      = SYM_VALID & SYM_READY;
    assign unit_end  = (cycle_cnt == CYC_LAST);
    assign phase_end = unit_end && (unit_cnt == last_unit);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            unit_cnt  <= '0;
            last_unit <= '0;
            LED       <= 1'b0;
            BUSY      <= 1'b0;
            SYM_READY <= 1'b0;
        end else begin
            state     <= state_nx;
            cycle_cnt <= cycle_nx;
            unit_cnt  <= unit_nx;
            last_unit <= last_nx;
            LED       <= (state_nx == S_MARK);
            BUSY      <= (state_nx != S_IDLE);
            SYM_READY <= (state_nx == S_IDLE);
        end
    end

    // last_unit holds N-1 for the running phase, so no multiply is needed
    always_comb begin
        state_nx = state;
        cycle_nx = cycle_cnt;
        unit_nx  = unit_cnt;
        last_nx  = last_unit;
        unique case (state)
            S_IDLE: begin
                cycle_nx = '0;
                unit_nx  = '0;
                if (take) begin
                    unique case (SYM)
                        2'b00: begin state_nx = S_MARK;  last_nx = 3'd0; end
                        2'b01: begin state_nx = S_MARK;  last_nx = 3'd2; end
                        2'b10: begin state_nx = S_SPACE; last_nx = 3'd2; end
                        default: begin state_nx = S_SPACE; last_nx = 3'd6; end
                    endcase
                end
            end
            S_MARK, S_SPACE: begin
                if (phase_end) begin
                    cycle_nx = '0;
                    unit_nx  = '0;
                    last_nx  = 3'd0;
                    state_nx = (state == S_MARK) ? S_SPACE : S_IDLE;
                end else if (unit_end) begin
                    cycle_nx = '0;
                    unit_nx  = unit_cnt + 3'd1;
                end else begin
                    cycle_nx = cycle_cnt + COUNT_BITS'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                cycle_nx = '0;
                unit_nx  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_morse_blink_tx.sv
// Directed bench for morse_blink_tx: unit=4 instance for timing/handshake,
// unit=2 instance for an SOS run-length scoreboard.
module tb_morse_blink_tx;

    logic       CLK;
    logic       RST_N;
    logic [1:0] sym4, sym2;
    logic       valid4, valid2;
    logic       rdy4, rdy2;
    logic       led4, led2;
    logic       busy4, busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    morse_blink_tx #(.CLK_FREQ(20), .UNIT_CYCLES(4), .COUNT_BITS(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .SYM(sym4), .SYM_VALID(valid4),
        .SYM_READY(rdy4), .LED(led4), .BUSY(busy4)
    );

    morse_blink_tx #(.CLK_FREQ(10), .UNIT_CYCLES(2), .COUNT_BITS(3)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .SYM(sym2), .SYM_VALID(valid2),
        .SYM_READY(rdy2), .LED(led2), .BUSY(busy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Plays one symbol on dut4 and measures mark/space lengths and the
    // sample index (1 = just after the transfer edge) where ready returns.
    task automatic play4(input logic [1:0] s, output int mark,
                         output int space, output int idle_at,
                         output bit busy_ok);
        mark = 0; space = 0; idle_at = -1; busy_ok = 1'b1;
        for (int w = 0; w < 100 && !rdy4; w++) @(negedge CLK);
        sym4 = s;
        valid4 = 1'b1;
        @(negedge CLK);
        valid4 = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            if (rdy4) begin
                idle_at = j;
                break;
            end
            if (!busy4) busy_ok = 1'b0;
            if (led4) mark++;
            else space++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        valid4 = 1'b0; valid2 = 1'b0;
        sym4 = 2'b00; sym2 = 2'b00;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (led4 !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", led4); end
        checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
        checks++;
        if (rdy4 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy4); end
        RST_N = 1'b1;
        #1;
        checks++;
        if (rdy4 !== 1'b0) begin errors++; $display("FAIL release_ready_early got %b want 0", rdy4); end
        @(negedge CLK);
        checks++;
        if (rdy4 !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", rdy4); end
        checks++;
        if (busy4 !== 1'b0 || led4 !== 1'b0) begin
            errors++; $display("FAIL release_idle got busy=%b led=%b want 0 0", busy4, led4);
        end
    endtask

    task automatic test_dot();
        int m, s, idle;
        bit bok;
        play4(2'b00, m, s, idle, bok);
        checks++;
        if (m != 4) begin errors++; $display("FAIL dot_mark got %0d want 4", m); end
        checks++;
        if (s != 4) begin errors++; $display("FAIL dot_space got %0d want 4", s); end
        checks++;
        if (idle != 9) begin errors++; $display("FAIL dot_idle got %0d want 9", idle); end
        checks++;
        if (!bok) begin errors++; $display("FAIL dot_busy got 0 want 1"); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, hi, lo, ghi, glo;
        bit seen;
        t1 = -1; t2 = -1; hi = 0; lo = 0; ghi = 0; glo = 0;
        sym4 = 2'b01;
        valid4 = 1'b1;
        for (int w = 0; w < 100 && !rdy4; w++) @(negedge CLK);
        t1 = cyc + 1;
        @(negedge CLK);
        sym4 = 2'b10;
        for (int j = 0; j < 100; j++) begin
            if (rdy4) begin
                t2 = cyc + 1;
                break;
            end
            if (led4) hi++;
            else lo++;
            @(negedge CLK);
        end
        @(negedge CLK);
        valid4 = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 100; j++) begin
            if (rdy4) begin
                seen = 1'b1;
                break;
            end
            if (led4) ghi++;
            else glo++;
            @(negedge CLK);
        end
        checks++;
        if (hi != 12) begin errors++; $display("FAIL dash_mark got %0d want 12", hi); end
        checks++;
        if (lo != 4) begin errors++; $display("FAIL dash_space got %0d want 4", lo); end
        checks++;
        if (t2 - t1 != 17) begin errors++; $display("FAIL b2b_spacing got %0d want 17", t2 - t1); end
        checks++;
        if (glo != 12 || ghi != 0 || !seen) begin
            errors++;
            $display("FAIL lgap_space got low=%0d high=%0d done=%0d want 12 0 1", glo, ghi, seen);
        end
    endtask

    task automatic test_word_gap();
        int blen, lhi;
        bit done;
        blen = 0; lhi = 0; done = 1'b0;
        for (int w = 0; w < 100 && !rdy4; w++) @(negedge CLK);
        sym4 = 2'b11;
        valid4 = 1'b1;
        @(negedge CLK);
        sym4 = 2'b00;
        for (int j = 0; j < 100; j++) begin
            if (rdy4) begin
                valid4 = 1'b0;
                done = 1'b1;
                break;
            end
            if (busy4 && !led4) blen++;
            if (led4) lhi++;
            valid4 = ~valid4;
            @(negedge CLK);
        end
        checks++;
        if (blen != 28 || !done) begin
            errors++; $display("FAIL wgap_busy got %0d done=%0d want 28 1", blen, done);
        end
        checks++;
        if (lhi != 0) begin errors++; $display("FAIL wgap_led got %0d want 0", lhi); end
        repeat (3) @(negedge CLK);
        checks++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b1) begin
            errors++; $display("FAIL wgap_no_extra got busy=%b ready=%b want 0 1", busy4, rdy4);
        end
    endtask

    task automatic test_reset_mid_dash();
        int m, s, idle;
        bit bok;
        for (int w = 0; w < 100 && !rdy4; w++) @(negedge CLK);
        sym4 = 2'b01;
        valid4 = 1'b1;
        @(negedge CLK);
        valid4 = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (led4 !== 1'b1) begin errors++; $display("FAIL middash_led got %b want 1", led4); end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (led4 !== 1'b0) begin errors++; $display("FAIL async_led got %b want 0", led4); end
        checks++;
        if (busy4 !== 1'b0 || rdy4 !== 1'b0) begin
            errors++; $display("FAIL async_flags got busy=%b ready=%b want 0 0", busy4, rdy4);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (rdy4 !== 1'b1 || busy4 !== 1'b0 || led4 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got ready=%b busy=%b led=%b want 1 0 0", rdy4, busy4, led4);
        end
        play4(2'b00, m, s, idle, bok);
        checks++;
        if (m != 4 || s != 4 || idle != 9) begin
            errors++; $display("FAIL post_reset_dot got %0d/%0d/%0d want 4/4/9", m, s, idle);
        end
    endtask

    task automatic test_sos();
        logic [1:0] seq[11];
        int exp_runs[18];
        int runs[$];
        int idx, cur_len;
        logic cur_val, first_val;
        bit pend, done;
        seq = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01,
                2'b10, 2'b00, 2'b00, 2'b00};
        exp_runs = '{2, 3, 2, 3, 2, 10, 6, 3, 6, 3, 6, 10,
                     2, 3, 2, 3, 2, 2};
        idx = 0; cur_len = 0; cur_val = 1'b1; first_val = 1'b0;
        pend = 1'b0; done = 1'b0;
        for (int w = 0; w < 100 && !rdy2; w++) @(negedge CLK);
        sym2 = seq[0];
        valid2 = 1'b1;
        pend = rdy2;
        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            if (pend) begin
                idx++;
                pend = 1'b0;
                if (idx < 11) sym2 = seq[idx];
                else valid2 = 1'b0;
            end
            if (rdy2 && idx == 11) begin
                done = 1'b1;
                break;
            end
            if (rdy2 && valid2) pend = 1'b1;
            if (cur_len == 0 && runs.size() == 0) begin
                first_val = led2;
                cur_val = led2;
                cur_len = 1;
            end else if (led2 == cur_val) begin
                cur_len++;
            end else begin
                runs.push_back(cur_len);
                cur_val = led2;
                cur_len = 1;
            end
        end
        if (cur_len > 0) runs.push_back(cur_len);
        checks++;
        if (!done) begin errors++; $display("FAIL sos_timeout got idx=%0d want 11", idx); end
        checks++;
        if (first_val !== 1'b1) begin errors++; $display("FAIL sos_first got %b want 1", first_val); end
        checks++;
        if (runs.size() != 18) begin
            errors++; $display("FAIL sos_runs got %0d want 18", runs.size());
        end
        for (int i = 0; i < 18 && i < runs.size(); i++) begin
            checks++;
            if (runs[i] != exp_runs[i]) begin
                errors++; $display("FAIL sos_run%0d got %0d want %0d", i, runs[i], exp_runs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dot();
        test_back_to_back();
        test_word_gap();
        test_reset_mid_dash();
        test_sos();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
